// File: rtl/regfile_writeback_queue.sv
// Write-side front end for a 16 x 16-bit register file: two round-robin producers, in-order FIFO, grant-driven drain.
// Optional forwarding lookup enabled by defining REGFILE_WB_FORWARD_EN.
module regfile_writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [3:0]  a_addr,
    input  logic [15:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [3:0]  b_addr,
    input  logic [15:0] b_data,
    input  logic        rf_grant,
    output logic        rf_write,
    output logic [3:0]  rf_addr,
    output logic [15:0] rf_wdata,
    output logic [15:0] pending,
    input  logic [3:0]  fwd_addr,
    output logic        fwd_hit,
    output logic [15:0] fwd_data
);
    localparam int PTR_W = $clog2(DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;
    localparam cnt_t FULL = cnt_t'(DEPTH);

    logic [3:0]  addr_mem [DEPTH];
    logic [15:0] data_mem [DEPTH];
    ptr_t        head, tail;
    cnt_t        count;
    logic        rr;
    logic        pop, push, room, grant_a, grant_b;

    // Handshake and drain decisions; reset gates every strobe so nothing leaks out mid-reset.
    always_comb begin
        pop      = rst_n && rf_grant && (count != '0);
        room     = (count < FULL) || pop;
        grant_a  = a_valid && (!b_valid || !rr);
        grant_b  = b_valid && (!a_valid || rr);
        a_ready  = rst_n && room && grant_a;
        b_ready  = rst_n && room && grant_b;
        push     = a_ready || b_ready;
        rf_write = pop;
        rf_addr  = pop ? addr_mem[head] : 4'h0;
        rf_wdata = pop ? data_mem[head] : 16'h0000;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            rr    <= 1'b0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (push && a_valid && b_valid) rr <= a_ready;
        end
    end

    // NOTE: the entry storage is deliberately unreset; count/head/tail alone decide which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= a_ready ? a_addr : b_addr;
            data_mem[tail] <= a_ready ? a_data : b_data;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        ptr_t off;
        pending = '0;
        off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = ptr_t'(i) - head;
            if ({1'b0, off} < count) pending[addr_mem[i]] = 1'b1;
        end
    end

`ifdef REGFILE_WB_FORWARD_EN
    // Walk from oldest to youngest so the last match seen is the youngest.
    always_comb begin
        ptr_t idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + ptr_t'(k);
            if ((cnt_t'(k) < count) && (addr_mem[idx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[idx];
            end
        end
    end
`else
    logic fwd_unused;
    assign fwd_unused = ^fwd_addr;
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench for regfile_writeback_queue: directed scenarios then random traffic against a queue model.
module tb_regfile_writeback_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst_n, a_valid, b_valid, rf_grant;
    logic [3:0]  a_addr, b_addr, fwd_addr;
    logic [15:0] a_data, b_data;
    logic        a_ready, b_ready, rf_write, fwd_hit;
    logic [3:0]  rf_addr;
    logic [15:0] rf_wdata, pending, fwd_data;

    int vectors = 0;
    int miscompares = 0;

    wb_t  q[$];
    logic rr_m = 1'b0;
    logic        last_a_ready, last_b_ready, last_rf_write;
    logic [3:0]  last_rf_addr;
    logic [15:0] last_rf_wdata;

    regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rf_grant(rf_grant), .rf_write(rf_write), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .pending(pending), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive, check outputs against the model, advance the model across the edge.
    task automatic step(input logic rn, input logic av, input logic [3:0] aa, input logic [15:0] ad,
                        input logic bv, input logic [3:0] ba, input logic [15:0] bd,
                        input logic g, input logic [3:0] fa);
        int          n;
        logic        epop, eroom, ga, gb, ea, eb, efh;
        logic [3:0]  era;
        logic [15:0] erd, epend, efd;
        rst_n = rn; a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd; rf_grant = g; fwd_addr = fa;
        #2;
        n     = q.size();
        epop  = rn && g && (n != 0);
        eroom = (n < DEPTH) || epop;
        ga    = av && (!bv || rr_m == 1'b0);
        gb    = bv && (!av || rr_m == 1'b1);
        ea    = rn && eroom && ga;
        eb    = rn && eroom && gb;
        era   = epop ? q[0].addr : 4'h0;
        erd   = epop ? q[0].data : 16'h0;
        epend = '0;
        efh   = 1'b0;
        efd   = '0;
        foreach (q[i]) begin
            epend[q[i].addr] = 1'b1;
`ifdef REGFILE_WB_FORWARD_EN
            if (q[i].addr == fa) begin
                efh = 1'b1;
                efd = q[i].data;
            end
`endif
        end
        check("a_ready", {31'b0, a_ready}, {31'b0, ea});
        check("b_ready", {31'b0, b_ready}, {31'b0, eb});
        check("rf_write", {31'b0, rf_write}, {31'b0, epop});
        check("rf_addr", {28'b0, rf_addr}, {28'b0, era});
        check("rf_wdata", {16'b0, rf_wdata}, {16'b0, erd});
        check("pending", {16'b0, pending}, {16'b0, epend});
        check("fwd_hit", {31'b0, fwd_hit}, {31'b0, efh});
        check("fwd_data", {16'b0, fwd_data}, {16'b0, efd});
        last_a_ready = a_ready; last_b_ready = b_ready; last_rf_write = rf_write;
        last_rf_addr = rf_addr; last_rf_wdata = rf_wdata;
        @(posedge clk);
        if (!rn) begin
            q.delete();
            rr_m = 1'b0;
        end else begin
            if (epop) void'(q.pop_front());
            if (ea) q.push_back('{addr: aa, data: ad});
            else if (eb) q.push_back('{addr: ba, data: bd});
            if (av && bv && (ea || eb)) rr_m = ea ? 1'b1 : 1'b0;  // opposite of the winner
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic g);
        step(1'b1, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, g, 4'h0);
    endtask

    initial begin
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; rf_grant = 1'b1;
        a_addr = '0; a_data = '0; b_addr = '0; b_data = '0; fwd_addr = '0;
        @(negedge clk);
        @(negedge clk);
        #2;
        check("rst_a_ready", {31'b0, a_ready}, 32'd0);
        check("rst_rf_write", {31'b0, rf_write}, 32'd0);
        check("rst_rf_addr", {28'b0, rf_addr}, 32'd0);
        check("rst_pending", {16'b0, pending}, 32'd0);
        check("rst_fwd_hit", {31'b0, fwd_hit}, 32'd0);
        @(negedge clk);

        // Single ALU write drains the following cycle.
        step(1'b1, 1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 16'h0, 1'b1, 4'd5);
        check("t1_a_ready", {31'b0, last_a_ready}, 32'd1);
        check("t1_pending_set", {16'b0, pending}, 32'h0020);
        idle(1'b1);
        check("t1_rf_write", {31'b0, last_rf_write}, 32'd1);
        check("t1_rf_addr", {28'b0, last_rf_addr}, 32'd5);
        check("t1_rf_wdata", {16'b0, last_rf_wdata}, 32'h1234);
        check("t1_pending_clr", {16'b0, pending}, 32'h0000);

        // Both producers always valid: A and B alternate.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 4'd1, 16'hAAAA, 1'b1, 4'd2, 16'hBBBB, 1'b1, 4'd1);
            check("t2_alt_a", {31'b0, last_a_ready}, {31'b0, (i % 2) == 0});
            check("t2_alt_b", {31'b0, last_b_ready}, {31'b0, (i % 2) == 1});
        end
        idle(1'b1);
        idle(1'b1);

        // Fill with no grant, then push and pop together while full.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 4'(6 + i), 16'(16'h0600 + i), 1'b0, 4'd0, 16'h0, 1'b0, 4'd7);
        step(1'b1, 1'b1, 4'd12, 16'hC0C0, 1'b1, 4'd13, 16'hD0D0, 1'b0, 4'd7);
        check("t3_full_a", {31'b0, last_a_ready}, 32'd0);
        check("t3_full_b", {31'b0, last_b_ready}, 32'd0);
        check("t3_full_pending", {16'b0, pending}, 32'h03C0);
        step(1'b1, 1'b1, 4'd12, 16'hC0C0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd12);
        check("t3_swap_a", {31'b0, last_a_ready}, 32'd1);
        check("t3_swap_addr", {28'b0, last_rf_addr}, 32'd6);
        check("t3_swap_pending", {16'b0, pending}, 32'h1380);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Two writes to one register: youngest data forwarded.
        step(1'b1, 1'b1, 4'd3, 16'h0001, 1'b0, 4'd0, 16'h0, 1'b0, 4'd3);
        step(1'b1, 1'b1, 4'd3, 16'h0002, 1'b0, 4'd0, 16'h0, 1'b0, 4'd3);
        idle(1'b0);
        check("t4_pending", {16'b0, pending}, 32'h0008);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Reset in the middle of a drain discards the queue.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 4'(8 + i), 16'(16'h0800 + i), 1'b0, 4'd0, 16'h0, 1'b0, 4'd8);
        step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd8);
        check("t5_rst_write", {31'b0, last_rf_write}, 32'd0);
        check("t5_rst_pending", {16'b0, pending}, 32'h0000);
        idle(1'b1);
        check("t5_no_write", {31'b0, last_rf_write}, 32'd0);

        // Random traffic with a narrow address range so forwarding hits often.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) != 0),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom),
                 ($urandom_range(0, 2) != 0), 4'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/regfile_writeback_queue.md
# regfile_writeback_queue

Write-side front end for the 16 x 16-bit register file. Accepts register writebacks from two producers (ALU result path and memory load path) over valid/ready handshakes, arbitrates round-robin, buffers accepted writes in an in-order FIFO, and drains one write per cycle into the register file's single write port whenever the control unit grants that port. Also exports a per-register pending mask for hazard detection and, optionally, a forwarding lookup of queued data.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- a_valid  in  1  ALU writeback request
- a_ready  out  1  ALU request accepted this cycle
- a_addr  in  4  ALU destination register
- a_data  in  16  ALU write data
- b_valid  in  1  load writeback request
- b_ready  out  1  load request accepted this cycle
- b_addr  in  4  load destination register
- b_data  in  16  load write data
- rf_grant  in  1  control unit yields the register-file write port this cycle
- rf_write  out  1  write strobe to register file
- rf_addr  out  4  register-file write address
- rf_wdata  out  16  register-file write data
- pending  out  16  bit r set while any queued entry targets register r
- fwd_addr  in  4  forwarding lookup address
- fwd_hit  out  1  queued entry exists for fwd_addr
- fwd_data  out  16  data of youngest queued entry for fwd_addr

## Operation
- pop = rf_grant && count != 0. On pop: rf_write=1, rf_addr/rf_wdata = head entry; otherwise rf_write=0, rf_addr=0, rf_wdata=0.
- room = (count < DEPTH) || pop. At most one push per cycle.
- Arbitration: only one valid -> it is granted; both valid -> grant side indicated by rr (0=A, 1=B). a_ready = room && grant_a; b_ready = room && grant_b. Ready may depend combinationally on valid.
- rr flips to the opposite of the winner only on a cycle where both valid and a push occurs; otherwise holds.
- Push writes {addr,data} at tail; pop advances head; count updates by push-pop (simultaneous push and pop leaves count unchanged, legal when full).
- Commit order equals acceptance order; two writes to the same register commit oldest first.
- pending: OR over valid entries of one-hot(addr); derived from registered state only (reflects contents after last edge, excludes same-cycle push).
- Forwarding compares fwd_addr against valid entries; youngest match wins. Registered state only.
- rst_n low: count, head, tail, rr cleared; a_ready, b_ready, rf_write forced 0; queued entries discarded (never written).

## Timing
- Reset values: a_ready=0, b_ready=0, rf_write=0, rf_addr=0, rf_wdata=0, pending=0, fwd_hit=0, fwd_data=0.
- Entry accepted at edge N is head no earlier than after edge N; earliest rf_write for it is cycle N+1 (one-cycle minimum latency; no same-cycle bypass to rf outputs).
- rf_write and rf_* outputs combinational from head state and rf_grant; register file captures on the following edge.
- pending bit sets the cycle after acceptance, clears the cycle after the last matching entry pops.
- Full with rf_grant=0: both readies 0, state holds indefinitely.
- Empty with rf_grant=1: rf_write=0.
- Reset asserted mid-drain: rf_write low in that same cycle; no partial write.
- Pointers wrap modulo DEPTH.

## Configuration
- REGFILE_WB_FORWARD_EN defined: fwd_hit/fwd_data implemented as described.
- Not defined: fwd_hit tied 0, fwd_data tied 0, fwd_addr ignored; ports remain present.

## Test plan
- Reset, rf_grant=1, a_valid one cycle with addr 5 data 0x1234 -> a_ready=1; next cycle rf_write=1, rf_addr=5, rf_wdata=0x1234; pending[5] high for exactly one cycle.
- Both valid every cycle (A addr 1 data 0xAAAA, B addr 2 data 0xBBBB), rf_grant=1 -> accepts alternate A,B,A,B; rf writes alternate 1,2,1,2.
- rf_grant=0, push 4 entries -> count 4, both readies 0; then rf_grant=1 with a_valid -> push and pop same cycle, count stays 4, order preserved.
- With macro: queue addr 3 data 0x0001 then addr 3 data 0x0002, rf_grant=0, fwd_addr=3 -> fwd_hit=1, fwd_data=0x0002, pending=0x0008; without macro fwd_hit=0.
- Three entries queued, rst_n low one cycle while rf_grant=1 -> rf_write=0 that cycle, afterwards pending=0, no writes emitted.
